// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, state encoding and unpacked-operand type
package fpu_pkg;

    // FCLASS one-hot bit positions
    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    localparam logic [7:0]  EXP_ALL_ONES  = 8'hFF;
    localparam logic [31:0] CANONICAL_NAN = 32'h7fc00000;

    // Skid-buffer occupancy; 2'b11 is illegal and recovers to EMPTY
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic [9:0]  cls;
    } unpacked_t;

endpackage

// File: rtl/fpu_operand_unpack_if.sv
// rtl/fpu_operand_unpack_if.sv - operand-pair input and unpacked-result output handshake bundle
// slave modport: the unpack stage; master modport: the producer/consumer side.
interface fpu_operand_unpack_if #(
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      op_a_i;
    logic [31:0]      op_b_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             sign_a_o;
    logic             sign_b_o;
    logic [7:0]       exp_a_o;
    logic [7:0]       exp_b_o;
    logic [23:0]      sig_a_o;
    logic [23:0]      sig_b_o;
    logic             is_nan_a_o;
    logic             is_nan_b_o;
    logic             is_signaling_o;
    logic [9:0]       class_a_o;
    logic [9:0]       class_b_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  in_valid_i, op_a_i, op_b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o,
               sig_a_o, sig_b_o, is_nan_a_o, is_nan_b_o, is_signaling_o,
               class_a_o, class_b_o, tag_o
    );

    modport master (
        output in_valid_i, op_a_i, op_b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o,
               sig_a_o, sig_b_o, is_nan_a_o, is_nan_b_o, is_signaling_o,
               class_a_o, class_b_o, tag_o
    );
endinterface

// File: rtl/fpu_classify.sv
// rtl/fpu_classify.sv - combinational split and FCLASS of one IEEE-754 single operand
// op_i: raw operand; unp_o: {sign, exp, sig24 with hidden bit, class10 one-hot}.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0] op_i,
    output unpacked_t   unp_o
);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [9:0]  cls;

    assign s = op_i[31];
    assign e = op_i[30:23];
    assign f = op_i[22:0];

    always_comb begin
        cls = '0;
        if (e == EXP_ALL_ONES) begin
            if (f == '0)       cls[s ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
            else if (f[22])    cls[FCLASS_QNAN] = 1'b1;
            else               cls[FCLASS_SNAN] = 1'b1;
        end else if (e == 8'h00) begin
            if (f == '0)       cls[s ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
            else               cls[s ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
        end else begin
            cls[s ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
        end
    end

    assign unp_o = '{sign: s, exp: e, sig: {(e != 8'h00), f}, cls: cls};

endmodule

// File: rtl/fpu_operand_unpack.sv
// rtl/fpu_operand_unpack.sv - registered operand unpack/classify stage with one-entry skid buffer
// clk_i/reset_i: clock and async active-high reset; bus: operand-pair in, unpacked fields out.
module fpu_operand_unpack
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    fpu_operand_unpack_if.slave  bus
);
    unpacked_t new_a, new_b;

    fpu_classify u_cls_a (.op_i(bus.op_a_i), .unp_o(new_a));
    fpu_classify u_cls_b (.op_i(bus.op_b_i), .unp_o(new_b));

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    unpacked_t        m_a_q, m_a_d, m_b_q, m_b_d;
    unpacked_t        s_a_q, s_a_d, s_b_q, s_b_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;

    logic acc, pop;
    assign acc = bus.in_valid_i & in_ready_q;
    assign pop = out_valid_q & bus.out_ready_i;

    always_comb begin
        state_d = state_q;
        m_a_d   = m_a_q;
        m_b_d   = m_b_q;
        m_tag_d = m_tag_q;
        s_a_d   = s_a_q;
        s_b_d   = s_b_q;
        s_tag_d = s_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    m_a_d   = new_a;
                    m_b_d   = new_b;
                    m_tag_d = bus.tag_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    m_a_d   = new_a;
                    m_b_d   = new_b;
                    m_tag_d = bus.tag_i;
                end else if (acc) begin
                    // Consumer stalled: park the newcomer behind M
                    s_a_d   = new_a;
                    s_b_d   = new_b;
                    s_tag_d = bus.tag_i;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    m_a_d   = s_a_q;
                    m_b_d   = s_b_q;
                    m_tag_d = s_tag_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Handshake outputs are registered copies of the next state
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d == ST_ONE) || (state_d == ST_FULL);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            m_tag_q     <= '0;
            s_a_q       <= '0;
            s_b_q       <= '0;
            s_tag_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            m_a_q       <= m_a_d;
            m_b_q       <= m_b_d;
            m_tag_q     <= m_tag_d;
            s_a_q       <= s_a_d;
            s_b_q       <= s_b_d;
            s_tag_q     <= s_tag_d;
        end
    end

    assign bus.in_ready_o     = in_ready_q;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.sign_a_o       = m_a_q.sign;
    assign bus.sign_b_o       = m_b_q.sign;
    assign bus.exp_a_o        = m_a_q.exp;
    assign bus.exp_b_o        = m_b_q.exp;
    assign bus.sig_a_o        = m_a_q.sig;
    assign bus.sig_b_o        = m_b_q.sig;
    assign bus.class_a_o      = m_a_q.cls;
    assign bus.class_b_o      = m_b_q.cls;
    assign bus.is_nan_a_o     = m_a_q.cls[FCLASS_SNAN] | m_a_q.cls[FCLASS_QNAN];
    assign bus.is_nan_b_o     = m_b_q.cls[FCLASS_SNAN] | m_b_q.cls[FCLASS_QNAN];
    assign bus.is_signaling_o = m_a_q.cls[FCLASS_SNAN] | m_b_q.cls[FCLASS_SNAN];
    assign bus.tag_o          = m_tag_q;

endmodule

// File: doc/fpu_operand_unpack.md
# fpu_operand_unpack

Registered front-end stage of the FPU arithmetic path. Accepts two raw IEEE-754 single-precision operands over a valid/ready handshake. Splits each operand into sign, exponent and 24-bit significand with the hidden bit restored, and classifies it. Drives the per-operand fields consumed by the min/max, compare and classify units downstream, and buffers one extra transaction so that `in_ready_o` is a pure register output.

## Interface

Reset is asynchronous and active-high on `reset_i`. The block has one clock, `clk_i`.

Parameters:

- `TAG_W`, default 5: width of the opaque sideband tag (rd / op-select) carried alongside the operands.

Ports:

- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `in_valid_i` in 1: an operand pair is offered.
- `in_ready_o` out 1: the stage can accept a pair.
- `op_a_i`, `op_b_i` in 32: raw IEEE-754 operands.
- `tag_i` in TAG_W: sideband tag.
- `out_valid_o` out 1: unpacked result is valid.
- `out_ready_i` in 1: the consumer accepts the result.
- `sign_a_o`, `sign_b_o` out 1: operand signs.
- `exp_a_o`, `exp_b_o` out 8: biased exponents, passed through unchanged.
- `sig_a_o`, `sig_b_o` out 24: `{hidden, frac[22:0]}`. `hidden = (exp != 0)`.
- `is_nan_a_o`, `is_nan_b_o` out 1: operand is a NaN (quiet or signaling).
- `is_signaling_o` out 1: at least one operand is an sNaN.
- `class_a_o`, `class_b_o` out 10: RISC-V FCLASS one-hot mask.
- `tag_o` out TAG_W: the tag that entered with the pair.

## Operation

- Classification per operand, with `e = op[30:23]`, `f = op[22:0]`, `s = op[31]`:
  - zero: `e == 0` and `f == 0`.
  - subnormal: `e == 0` and `f != 0`.
  - normal: `e` is neither 0 nor 0xFF.
  - infinity: `e == 0xFF` and `f == 0`.
  - sNaN: `e == 0xFF`, `f != 0`, `f[22] == 0`.
  - qNaN: `e == 0xFF` and `f[22] == 1`.
- FCLASS bit mapping:
  - bit 0: -inf.
  - bit 1: -normal.
  - bit 2: -subnormal.
  - bit 3: -0.
  - bit 4: +0.
  - bit 5: +subnormal.
  - bit 6: +normal.
  - bit 7: +inf.
  - bit 8: sNaN (either sign).
  - bit 9: qNaN (either sign).
  - Exactly one bit is set per operand.
- `is_nan_x_o = class[8] | class[9]`. `is_signaling_o = class_a[8] | class_b[8]`.
- Classification is computed combinationally on the input. The result is stored in the registers; outputs never depend combinationally on inputs.
- The block holds two entries, main (M) and skid (S). States:
  - EMPTY: `out_valid_o = 0`, `in_ready_o = 1`.
  - ONE: M valid, `out_valid_o = 1`, `in_ready_o = 1`.
  - FULL: M and S valid, `out_valid_o = 1`, `in_ready_o = 0`.
- Let `acc = in_valid_i & in_ready_o` and `pop = out_valid_o & out_ready_i`. Transitions:
  - EMPTY + acc → ONE; the new pair loads into M.
  - ONE + acc + pop → ONE; the new pair loads into M.
  - ONE + acc + !pop → FULL; the new pair loads into S.
  - ONE + pop + !acc → EMPTY.
  - FULL + pop → ONE; S moves into M. No accept is possible in FULL.
  - All other combinations hold state and data.
- Ordering is strictly FIFO; the tag always travels with its pair.
- Output fields are stable while `out_valid_o = 1` and `out_ready_i = 0`.
- Illegal state encoding returns to EMPTY.

## Timing

- Latency is 1 cycle: a pair accepted at edge N is visible on the outputs after edge N.
- Throughput is one pair per cycle when the consumer is always ready.
- `in_ready_o` is registered, derived from state only.
- On `reset_i` assertion, immediately and asynchronously:
  - state is EMPTY, `out_valid_o = 0`, `in_ready_o = 1`.
  - all data outputs are 0, including `class_*_o = 0` and `tag_o = 0`.
- Reset mid-transfer discards both M and S. No partial pair emerges after reset deasserts.
- An accept on the first edge after reset deassertion is legal.

## Structure

- Shared `fpu_pkg` holds:
  - FCLASS bit index constants (`FCLASS_NEG_INF` … `FCLASS_QNAN`).
  - `EXP_ALL_ONES = 8'hFF`.
  - `CANONICAL_NAN = 32'h7fc00000`.
  - State encoding constants.
- One natural combinational sub-module, `fpu_classify`. It maps 32 bits to `{sign, exp, sig24, class10}` and is instantiated once per operand, before the registers.
- The skid/state logic lives in the top module.

## Test plan

- Single pair `0x3F800000`, `0xC0000000`:
  - Result appears after 1 cycle.
  - A: `sign 0`, `exp 0x7F`, `sig 0x800000`, `class 0x040`.
  - B: `sign 1`, `exp 0x80`, `sig 0x800000`, `class 0x002`.
  - `is_signaling_o = 0`.
- Special operands:
  - `0x7F800001` → `class 0x100`, `is_nan = 1`, `is_signaling_o = 1`.
  - `0xFFC00000` → `class 0x200`.
  - `0x00000001` → `sig 0x000001`, `class 0x020`.
  - `0x80000000` → `class 0x008`.
- Backpressure, with `out_ready_i = 0` and three pairs offered back-to-back:
  - Pairs 1 and 2 are accepted.
  - `in_ready_o` drops after the second accept; pair 3 stalls.
  - Releasing `out_ready_i` yields tags 1, 2, 3 in order with no loss or duplication.
- Streaming: `out_ready_i = 1` and 100 random pairs, one per cycle → 100 results, each 1 cycle late, fields matching a reference model; `in_ready_o` stays 1 throughout.
- Asynchronous reset asserted between clock edges while FULL → immediately `out_valid_o = 0`, `in_ready_o = 1`, outputs 0. After deassertion, the next accepted pair is the first one output.
